// File: rtl/two_comp_deser_if.sv
// Bus bundle for two_comp_deser: serial input handshake, parallel output
// handshake and the busy indicator. The clock and reset stay plain ports
// on the block.
//
// Handshake semantics (both directions): a transfer happens on a rising
// clock edge exactly when valid && ready are both high. The producer holds
// its data stable while valid is high and ready is low. in_ready does not
// depend on in_valid. out_valid does not depend on out_ready.
interface two_comp_deser_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             start;
    logic             in;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    // Producer of serial bits and consumer of decoded words
    modport master (
        output in_valid,
        output start,
        output in,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_valid,
        input  busy
    );

    // The deserialiser itself
    modport slave (
        input  in_valid,
        input  start,
        input  in,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_valid,
        output busy
    );
endinterface

// File: rtl/two_comp_deser.sv
// two_comp_deser: serial (LSB first) two's-complement negator and deserialiser.
// Each accepted bit is negated on the fly with the serial rule "copy bits up
// to and including the first 1, invert everything after it". The decoded
// bit enters at the MSB end of a shift register. When the last bit of a
// frame is accepted, the finished word is loaded into out_data and held
// until the consumer takes it.
//
// Optional feature: define TWO_COMP_DESER_OVF_EN to add the ovf output. It
// flags the one input word (1 followed by WIDTH-1 zeros) whose negation
// overflows.
module two_comp_deser #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    two_comp_deser_if.slave    bus,
    output logic [1:0]         dbg_state_o
`ifdef TWO_COMP_DESER_OVF_EN
    ,
    output logic               ovf
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              seen1_q, seen1_d;
    // Only the upper WIDTH-1 bits of the partial word need storage. The
    // final decoded bit goes straight into out_data together with them.
    logic [WIDTH-1:1]  shreg_q, shreg_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
`ifdef TWO_COMP_DESER_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    logic              accept;     // bit transferred this cycle
    logic              restart;    // transferred bit carries start
    logic              take_bit;   // transferred bit belongs to a frame
    logic              seen1_eff;  // seen1 as seen by the current bit
    logic              dbit;       // decoded bit
    logic [CW-1:0]     cnt_eff;    // index of the current bit
    logic [WIDTH-1:0]  shifted;    // partial word including the current bit

    // Next-state, datapath and handshake decisions
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        seen1_d     = seen1_q;
        shreg_d     = shreg_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
`ifdef TWO_COMP_DESER_OVF_EN
        ovf_d       = ovf_q;
`endif

        accept    = bus.in_valid && (state_q != HOLD);
        restart   = accept && bus.start;
        // IDLE only takes a bit that opens a frame. SHIFT takes every
        // transferred bit.
        take_bit  = restart || (accept && (state_q == SHIFT));
        seen1_eff = restart ? 1'b0 : seen1_q;
        cnt_eff   = restart ? '0 : cnt_q;
        dbit      = seen1_eff ? ~bus.in : bus.in;
        shifted   = {dbit, shreg_q};

        case (state_q)
            IDLE, SHIFT: begin
                if (take_bit) begin
                    seen1_d = seen1_eff | bus.in;
                    shreg_d = shifted[WIDTH-1:1];
                    if (cnt_eff == LAST_IDX) begin
                        out_data_d  = shifted;
                        out_valid_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = HOLD;
`ifdef TWO_COMP_DESER_OVF_EN
                        // Input word 100..0: no 1 before the final bit,
                        // and the final bit is 1.
                        ovf_d       = ~seen1_eff & bus.in;
`endif
                    end else begin
                        cnt_d   = cnt_eff + CW'(1);
                        state_d = SHIFT;
                    end
                end
            end
            HOLD: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
`ifdef TWO_COMP_DESER_OVF_EN
                    ovf_d       = 1'b0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            seen1_q     <= 1'b0;
            shreg_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
`ifdef TWO_COMP_DESER_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            seen1_q     <= seen1_d;
            shreg_q     <= shreg_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
`ifdef TWO_COMP_DESER_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q != HOLD);
    assign bus.busy      = (state_q == SHIFT);
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign dbg_state_o   = state_q;
`ifdef TWO_COMP_DESER_OVF_EN
    assign ovf           = ovf_q;
`endif

endmodule

// File: tb/tb_two_comp_deser.sv
// Testbench for two_comp_deser (WIDTH=8). It contains a frame-level
// reference model: bits are collected into a queue, and the finished word
// is negated arithmetically. It also keeps an expected queue of decoded
// words that is checked at every output handshake.
module tb_two_comp_deser;

    localparam int W = 8;

    logic clk;
    logic rst;
    logic [1:0] dbg_state;
`ifdef TWO_COMP_DESER_OVF_EN
    logic ovf;
`endif

    two_comp_deser_if #(.WIDTH(W)) bus ();

    two_comp_deser #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
`ifdef TWO_COMP_DESER_OVF_EN
        ,
        .ovf         (ovf)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard / model state ----------------
    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_q[$];
    bit           frame_bits[$];
    bit           m_in_frame;
    bit           m_pending;
    bit           m_ovf;
    logic [W-1:0] m_out;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        frame_bits.delete();
        exp_q.delete();
        m_in_frame = 1'b0;
        m_pending  = 1'b0;
        m_ovf      = 1'b0;
        m_out      = '0;
    endtask

    // One clock edge in frame terms: consume a pending word, or collect a bit.
    task automatic model_edge(input bit v, input bit s, input bit b, input bit r);
        logic [W-1:0] word;
        if (m_pending) begin
            if (r) begin
                m_pending = 1'b0;
                m_ovf     = 1'b0;
            end
        end else if (v) begin
            if (s) begin
                frame_bits.delete();
                frame_bits.push_back(b);
                m_in_frame = 1'b1;
            end else if (m_in_frame) begin
                frame_bits.push_back(b);
            end
            if (m_in_frame && frame_bits.size() == W) begin
                word = '0;
                for (int i = 0; i < W; i++) word[i] = frame_bits[i];
                m_out      = W'(0) - word;
                m_ovf      = (word == (W'(1) << (W - 1)));
                m_pending  = 1'b1;
                m_in_frame = 1'b0;
                frame_bits.delete();
                exp_q.push_back(m_out);
            end
        end
    endtask

    task automatic check_outputs();
        check("out_valid", 32'(bus.out_valid), 32'(m_pending));
        check("in_ready",  32'(bus.in_ready),  32'(!m_pending));
        check("busy",      32'(bus.busy),      32'(m_in_frame));
        check("out_data",  32'(bus.out_data),  32'(m_out));
`ifdef TWO_COMP_DESER_OVF_EN
        check("ovf",       32'(ovf),           32'(m_ovf));
`endif
    endtask

    // ---------------- driver tasks ----------------
    // Called about 1 time unit after a rising edge. It drives the inputs,
    // checks an output handshake, advances one edge and checks the outputs.
    task automatic step(input bit v, input bit s, input bit b, input bit r);
        bus.in_valid  = v;
        bus.start     = s;
        bus.in        = b;
        bus.out_ready = r;
        #2;
        if (bus.out_valid && r) begin
            if (exp_q.size() == 0) check("hs_spurious", 32'(1), 32'(0));
            else                   check("hs_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
        end
        @(posedge clk);
        model_edge(v, s, b, r);
        #1;
        check_outputs();
    endtask

    task automatic send_word(input logic [W-1:0] word, input bit r);
        for (int i = 0; i < W; i++) step(1'b1, i == 0, word[i], r);
    endtask

    task automatic drain();
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Reset is asserted away from any clock edge and checked at once.
    task automatic apply_reset();
        bus.in_valid  = 1'b0;
        bus.start     = 1'b0;
        bus.in        = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("rst_out_valid", 32'(bus.out_valid), 32'(0));
        check("rst_out_data",  32'(bus.out_data),  32'(0));
        check("rst_busy",      32'(bus.busy),      32'(0));
        check("rst_in_ready",  32'(bus.in_ready),  32'(1));
`ifdef TWO_COMP_DESER_OVF_EN
        check("rst_ovf",       32'(ovf),           32'(0));
`endif
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0;
        model_reset();
        apply_reset();

        // 0xFA -> 0x06, visible right after the last bit, then gone
        send_word(8'hFA, 1'b1);
        check("fa_data",  32'(bus.out_data),  32'h06);
        check("fa_valid", 32'(bus.out_valid), 32'(1));
        drain();
        check("fa_valid_drop", 32'(bus.out_valid), 32'(0));

        // all-zero word and the overflow word
        send_word(8'h00, 1'b1);
        check("zero_data", 32'(bus.out_data), 32'h00);
        drain();
        send_word(8'h80, 1'b1);
        check("min_data", 32'(bus.out_data), 32'h80);
`ifdef TWO_COMP_DESER_OVF_EN
        check("min_ovf", 32'(ovf), 32'(1));
`endif
        drain();

        // 0xFF with a 3-cycle in_valid gap after bit 4
        for (int i = 0; i < 4; i++) step(1'b1, i == 0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, $urandom_range(0, 1), $urandom_range(0, 1), 1'b1);
        for (int i = 4; i < W; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
        check("gap_data", 32'(bus.out_data), 32'h01);
        drain();

        // start reasserted at bit 5: partial frame dropped, 0x03 -> 0xFD
        for (int i = 0; i < 4; i++) step(1'b1, i == 0, 1'b1, 1'b1);
        send_word(8'h03, 1'b1);
        check("abort_data", 32'(bus.out_data), 32'hFD);
        drain();

        // consumer stalls 5 cycles; offered bits are ignored
        send_word(8'h5A, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, $urandom_range(0, 1), $urandom_range(0, 1), 1'b0);
        check("hold_data",  32'(bus.out_data), 32'hA6);
        check("hold_ready", 32'(bus.in_ready), 32'(0));
        drain();
        check("hold_release", 32'(bus.out_valid), 32'(0));

        // reset at bit 6, then 0x02 -> 0xFE
        for (int i = 0; i < 5; i++) step(1'b1, i == 0, 1'b1, 1'b1);
        apply_reset();
        send_word(8'h02, 1'b1);
        check("post_rst_data", 32'(bus.out_data), 32'hFE);
        drain();

        // random whole words with a randomly slow consumer
        for (int n = 0; n < 30; n++) begin
            send_word(W'($urandom), $urandom_range(0, 1));
            for (int k = 0; k < 6 && m_pending; k++) step(1'b0, 1'b0, 1'b0, $urandom_range(0, 1));
            if (m_pending) drain();
        end

        // fully random bit stream: gaps, stray starts, stalls
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 1), $urandom_range(0, 2) != 0);
        end
        for (int n = 0; n < 3; n++) drain();
        check("exp_q_empty", 32'(exp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/two_comp_deser.md
TWO_COMP_DESER -- requirements
Module: two_comp_deser

Interface
REQ-001 Parameter: WIDTH, default 8, word length in bits (WIDTH >= 2).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-low.
REQ-004 in_valid  input  1  serial bit on `in` offered this cycle.
REQ-005 start  input  1  qualifies the offered bit as the LSB (first bit) of a new frame.
REQ-006 in  input  1  serial two's-complement bit, LSB first.
REQ-007 in_ready  output  1  block accepts the offered bit this cycle.
REQ-008 out_data  output  WIDTH  decoded word, i.e. the two's complement of the received word.
REQ-009 out_valid  output  1  out_data holds a complete decoded word.
REQ-010 out_ready  input  1  consumer accepts out_data.
REQ-011 busy  output  1  frame reception in progress.
REQ-012 ovf  output  1  overflow flag; present only under TWO_COMP_DESER_OVF_EN.

Function
REQ-013 A bit transfers on a rising edge when in_valid && in_ready.
REQ-014 States SHALL be IDLE, SHIFT and HOLD; in_ready = 1 in IDLE and SHIFT, 0 in HOLD; busy = 1 only in SHIFT.
REQ-015 IDLE: bits transferred with start=0 are discarded; a bit transferred with start=1 begins a frame and moves to SHIFT, or to HOLD when WIDTH bits are complete.
REQ-016 Decode rule, serial Mealy: flag `seen1` clears at frame start; decoded bit = in while seen1=0, and ~in once seen1=1; seen1 sets after any transferred 1.
REQ-017 Each decoded bit SHALL shift in at the MSB end: shreg <= {dbit, shreg[WIDTH-1:1]}; bit counter counts 0..WIDTH-1.
REQ-018 On the edge accepting bit WIDTH-1, out_data SHALL load the completed word, out_valid SHALL rise, and the state SHALL go to HOLD; latency last bit -> out_valid is zero extra cycles.
REQ-019 HOLD: out_data and out_valid stable until out_valid && out_ready at an edge; then out_valid drops and the state goes to IDLE.
REQ-020 start=1 on a transferred bit in SHIFT SHALL abort the partial frame, restart the counter and seen1, and take this bit as the new LSB.
REQ-021 in_valid=0 in SHIFT SHALL stall: counter, shreg and seen1 hold.
REQ-022 An all-zero input word SHALL decode to all-zero output.
REQ-023 Arithmetic is modulo 2^WIDTH; the input word 100...0 decodes to 100...0.

Reset
REQ-024 rst low SHALL force immediately: state IDLE, counter 0, seen1 0, shreg 0, out_data 0, out_valid 0, busy 0, ovf 0.
REQ-025 Reset mid-frame or in HOLD discards all data; the first frame after reset needs start=1.

Configuration
REQ-026 Macro TWO_COMP_DESER_OVF_EN defined: ovf is a port, set with out_valid when the input word equals 1 followed by WIDTH-1 zeros, and cleared on the handshake or reset.
REQ-027 Macro undefined: no ovf port and no overflow logic; all other behaviour unchanged.

Verification (WIDTH=8)
REQ-028 Bits 0,1,0,1,1,1,1,1 (0xFA), start on the first bit, out_ready=1 -> out_valid for one cycle after bit 8 with out_data=0x06.
REQ-029 Bits 0,0,0,0,0,0,0,0 -> out_data=0x00; input 0x80 -> out_data=0x80; ovf=1 only under the macro.
REQ-030 in_valid gap of 3 cycles after bit 4 of 0xFF -> no counter advance during the gap; out_data=0x01.
REQ-031 start reasserted at bit 5 of a frame, then 8 bits of 0x03 -> single out_valid with out_data=0xFD.
REQ-032 out_ready=0 for 5 cycles after completion -> in_ready=0, out_data stable, offered bits ignored; completes on out_ready=1.
REQ-033 rst pulled low at bit 6 -> outputs zero at once; the next start frame 0x02 decodes to 0xFE.
